// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// The entry layout is what the RX FIFO stores and what the CPU side reads back.
package uart_pkg;

   typedef struct packed {
      logic       parity_err;
      logic       frame_err;
      logic [7:0] data;
   } uart_rx_entry_t;

   localparam int FRAME_W   = 12;
   localparam int START_BIT = 0;
   localparam int DATA_LSB  = 1;

   // Only 6, 7 and 8 are honoured as data widths; every other code selects 5 bits.
   function automatic logic [3:0] data_bits(input logic [3:0] number_data);
      case (number_data)
         4'd6, 4'd7, 4'd8: return number_data;
         default:          return 4'd5;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Show-ahead FIFO of received entries with push/pop/flush and an occupancy counter.
// The head entry is visible combinationally; it reads as zero while empty.
module uart_rx_sync_fifo
   import uart_pkg::*;
#(
   parameter  int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                push,
   input  uart_rx_entry_t      push_data,
   input  logic                pop,
   output uart_rx_entry_t      head,
   output logic [ADDR_W:0]     count,
   output logic                full,
   output logic                empty
);

   uart_rx_entry_t    mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_reg;
   logic [ADDR_W-1:0] rd_ptr_reg;
   logic [ADDR_W:0]   count_reg;
   logic              do_push;
   logic              do_pop;

   assign full    = (count_reg == (ADDR_W+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;
   assign head    = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_frame_fifo.sv
// UART RX back end: checks parity/stop bits of each raw frame and queues
// {error flags, data} for the CPU, with sticky overrun and a level interrupt.
module uart_rx_frame_fifo
   import uart_pkg::*;
#(
   parameter  int DEPTH   = 16,
   parameter  int IRQ_LVL = 1,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              frame_valid_i,
   input  logic [11:0]       frame_i,
   input  logic [3:0]        number_data_i,
   input  logic              parity_en_i,
   input  logic              parity_odd_i,
   input  logic              stop_two_i,
   input  logic              rx_en_i,
   input  logic              flush_i,
   input  logic              rd_en_i,
   output logic [7:0]        rx_data_o,
   output logic              rx_parity_err_o,
   output logic              rx_frame_err_o,
   output logic              rx_empty_o,
   output logic              rx_full_o,
   output logic [ADDR_W:0]   rx_count_o,
   output logic              rx_overrun_o,
   output logic              rx_irq_o
);

   logic [3:0]     n_bits;
   logic [3:0]     stop_pos;
   logic [7:0]     data;
   logic           parity_bit;
   uart_rx_entry_t check_entry;
   uart_rx_entry_t stage_entry_reg;
   logic           stage_valid_reg;
   logic           overrun_reg;
   uart_rx_entry_t head;

   assign n_bits   = data_bits(number_data_i);
   assign stop_pos = n_bits + 4'd1 + {3'b000, parity_en_i};

   // Data bits above the configured width are forced to zero.
   for (genvar gi = 0; gi < 8; gi++) begin : g_data
      assign data[gi] = (4'(gi) < n_bits) ? frame_i[DATA_LSB+gi] : 1'b0;
   end

   assign parity_bit             = frame_i[n_bits + 4'd1];
   assign check_entry.data       = data;
   assign check_entry.parity_err = parity_en_i & (^data ^ parity_bit ^ parity_odd_i);
   assign check_entry.frame_err  = frame_i[START_BIT] | ~frame_i[stop_pos]
                                 | (stop_two_i & ~frame_i[stop_pos + 4'd1]);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stage_valid_reg <= 1'b0;
         stage_entry_reg <= '0;
         overrun_reg     <= 1'b0;
      end else begin
         stage_valid_reg <= frame_valid_i & rx_en_i & ~flush_i;
         if (frame_valid_i && rx_en_i) stage_entry_reg <= check_entry;
         if (flush_i) begin
            overrun_reg <= 1'b0;
         end else if (stage_valid_reg && rx_full_o && !rd_en_i) begin
            overrun_reg <= 1'b1;
         end
      end
   end

   uart_rx_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .flush     (flush_i),
      .push      (stage_valid_reg),
      .push_data (stage_entry_reg),
      .pop       (rd_en_i),
      .head      (head),
      .count     (rx_count_o),
      .full      (rx_full_o),
      .empty     (rx_empty_o)
   );

   assign rx_data_o       = head.data;
   assign rx_parity_err_o = head.parity_err;
   assign rx_frame_err_o  = head.frame_err;
   assign rx_overrun_o    = overrun_reg;
   assign rx_irq_o        = (rx_count_o >= (ADDR_W+1)'(IRQ_LVL));

endmodule

// File: tb/tb_uart_rx_frame_fifo.sv
// Directed bench: stimulus queues expected entries, a negedge monitor checks every pop.
module tb_uart_rx_frame_fifo;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_valid = 1'b0;
   logic [11:0] frame = '0;
   logic [3:0]  number_data = 4'd8;
   logic        parity_en = 1'b0;
   logic        parity_odd = 1'b0;
   logic        stop_two = 1'b0;
   logic        rx_en = 1'b1;
   logic        flush = 1'b0;
   logic        rd_en = 1'b0;
   logic [7:0]  rx_data;
   logic        rx_parity_err;
   logic        rx_frame_err;
   logic        rx_empty;
   logic        rx_full;
   logic [4:0]  rx_count;
   logic        rx_overrun;
   logic        rx_irq;

   int          errors = 0;
   int          checks = 0;
   logic [9:0]  sb[$];

   always #5 clk = ~clk;

   uart_rx_frame_fifo dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .frame_valid_i   (frame_valid),
      .frame_i         (frame),
      .number_data_i   (number_data),
      .parity_en_i     (parity_en),
      .parity_odd_i    (parity_odd),
      .stop_two_i      (stop_two),
      .rx_en_i         (rx_en),
      .flush_i         (flush),
      .rd_en_i         (rd_en),
      .rx_data_o       (rx_data),
      .rx_parity_err_o (rx_parity_err),
      .rx_frame_err_o  (rx_frame_err),
      .rx_empty_o      (rx_empty),
      .rx_full_o       (rx_full),
      .rx_count_o      (rx_count),
      .rx_overrun_o    (rx_overrun),
      .rx_irq_o        (rx_irq)
   );

   // Monitor: every accepted pop is compared against the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && rd_en && !rx_empty) begin
         logic [9:0] exp_e;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL pop: got %h, scoreboard empty", {rx_parity_err, rx_frame_err, rx_data});
         end else begin
            exp_e = sb.pop_front();
            if ({rx_parity_err, rx_frame_err, rx_data} !== exp_e) begin
               errors++;
               $display("FAIL pop: got {pe,fe,data}=%h need %h", {rx_parity_err, rx_frame_err, rx_data}, exp_e);
            end else begin
               $display("pop  data=%h pe=%0b fe=%0b ok", rx_data, rx_parity_err, rx_frame_err);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h need %0h", name, act, req);
      end else begin
         $display("chk  %s = %0h ok", name, act);
      end
   endtask

   // Presents one frame for the coming cycle; frame_valid stays high until idle().
   task automatic send(input logic [11:0] f, input logic [3:0] nd, input logic pe,
                       input logic odd, input logic two, input logic [9:0] exp_e, input bit accept);
      @(posedge clk); #1;
      frame = f; number_data = nd; parity_en = pe; parity_odd = odd; stop_two = two;
      frame_valid = 1'b1;
      if (accept) sb.push_back(exp_e);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      frame_valid = 1'b0;
   endtask

   task automatic pop_n(input int k);
      @(posedge clk); #1;
      rd_en = 1'b1;
      repeat (k) @(posedge clk);
      #1 rd_en = 1'b0;
   endtask

   initial begin
      #1;
      chk("reset_empty", 32'(rx_empty), 32'd1);
      chk("reset_count", 32'(rx_count), 32'd0);
      chk("reset_irq", 32'(rx_irq), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // 8N1 0xA5, latency two cycles
      send(12'h34A, 4'd8, 1'b0, 1'b0, 1'b0, {2'b00, 8'hA5}, 1'b1);
      idle();
      chk("t1_latency_empty", 32'(rx_empty), 32'd1);
      @(posedge clk); #1;
      chk("t1_data", 32'(rx_data), 32'hA5);
      chk("t1_count", 32'(rx_count), 32'd1);
      chk("t1_irq", 32'(rx_irq), 32'd1);
      pop_n(1);

      // 7E1 with wrong even parity, then same frame with odd parity
      send(12'h3AA, 4'd7, 1'b1, 1'b0, 1'b0, {2'b10, 8'h55}, 1'b1);
      send(12'h3AA, 4'd7, 1'b1, 1'b1, 1'b0, {2'b00, 8'h55}, 1'b1);
      idle();
      @(posedge clk); #1;
      chk("t2_parity_err", 32'(rx_parity_err), 32'd1);
      pop_n(2);

      // 8N2 with bad second stop bit; 5N1 with junk above the stop bit
      send(12'h278, 4'd8, 1'b0, 1'b0, 1'b1, {2'b01, 8'h3C}, 1'b1);
      send(12'h87E, 4'd0, 1'b0, 1'b0, 1'b0, {2'b00, 8'h1F}, 1'b1);
      idle();
      @(posedge clk); #1;
      chk("t3_frame_err", 32'(rx_frame_err), 32'd1);
      pop_n(2);

      // Fill back-to-back, 17th frame overruns
      for (int i = 0; i < 17; i++) begin
         send(12'h200 | 12'(i << 1), 4'd8, 1'b0, 1'b0, 1'b0, {2'b00, 8'(i)}, i < 16);
      end
      idle();
      @(posedge clk); #1;
      chk("t4_full", 32'(rx_full), 32'd1);
      chk("t4_overrun", 32'(rx_overrun), 32'd1);
      chk("t4_count", 32'(rx_count), 32'd16);
      pop_n(16);
      chk("t4_empty", 32'(rx_empty), 32'd1);
      chk("t4_overrun_sticky", 32'(rx_overrun), 32'd1);

      // Flush clears overrun; refill and push+pop while full
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      chk("t5_flush_overrun", 32'(rx_overrun), 32'd0);
      for (int i = 0; i < 16; i++) begin
         send(12'h200 | 12'((16 + i) << 1), 4'd8, 1'b0, 1'b0, 1'b0, {2'b00, 8'(16 + i)}, 1'b1);
      end
      idle();
      send(12'h3DC, 4'd8, 1'b0, 1'b0, 1'b0, {2'b00, 8'hEE}, 1'b1);
      @(posedge clk); #1;
      frame_valid = 1'b0;
      rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
      chk("t5_count", 32'(rx_count), 32'd16);
      chk("t5_head", 32'(rx_data), 32'h11);
      chk("t5_no_overrun", 32'(rx_overrun), 32'd0);
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      sb.delete();
      chk("t5_flush_count", 32'(rx_count), 32'd0);
      chk("t5_flush_empty", 32'(rx_empty), 32'd1);

      // Receiver disabled drops frames without overrun
      rx_en = 1'b0;
      send(12'h34A, 4'd8, 1'b0, 1'b0, 1'b0, {2'b00, 8'hA5}, 1'b0);
      send(12'h34A, 4'd8, 1'b0, 1'b0, 1'b0, {2'b00, 8'hA5}, 1'b0);
      idle();
      @(posedge clk); #1;
      chk("t6_disabled_count", 32'(rx_count), 32'd0);
      chk("t6_disabled_overrun", 32'(rx_overrun), 32'd0);
      rx_en = 1'b1;

      // Async reset with three entries held
      for (int i = 0; i < 3; i++) begin
         send(12'h200 | 12'((i + 3) << 1), 4'd8, 1'b0, 1'b0, 1'b0, {2'b00, 8'(i + 3)}, 1'b1);
      end
      idle();
      @(posedge clk); #1;
      chk("t6_held_count", 32'(rx_count), 32'd3);
      #3 rst_n = 1'b0;
      #1;
      sb.delete();
      chk("t6_rst_count", 32'(rx_count), 32'd0);
      chk("t6_rst_empty", 32'(rx_empty), 32'd1);
      chk("t6_rst_data", 32'(rx_data), 32'd0);
      chk("t6_rst_irq", 32'(rx_irq), 32'd0);
      chk("t6_rst_full", 32'(rx_full), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("t6_post_rst_empty", 32'(rx_empty), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
